// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps one request in flight to instruction memory,
// and queues PC-tagged words for decode. A redirect flushes the queue and the in-flight fetch.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        instr_ready_i
);
    // state     | meaning
    // S_REQ     | no fetch in flight; issue one when the queue has room
    // S_WAIT    | one fetch in flight; its response is pushed
    // S_DISCARD | in-flight fetch was flushed; its response is dropped
    localparam int unsigned  PW       = $clog2(DEPTH);
    localparam logic [PW:0]  LP_DEPTH = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_req_pc;
    logic [PW:0]     r_count;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [31:0]     r_instr_mem [DEPTH];
    logic [31:0]     r_pc_mem    [DEPTH];

    logic w_valid;
    logic w_issue;
    logic w_push;
    logic w_pop;

    assign w_valid = (r_count != '0);
    assign w_issue = rst_i && !redirect_i && (r_state == S_REQ) && (r_count < LP_DEPTH);
    assign w_push  = rst_i && !redirect_i && (r_state == S_WAIT) && imem_valid_i;
    assign w_pop   = rst_i && !redirect_i && w_valid && instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_i) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            // A response landing in the redirect cycle retires the in-flight fetch now
            if (r_state == S_WAIT) begin
                r_state <= imem_valid_i ? S_REQ : S_DISCARD;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_issue) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid_i) r_state <= S_REQ;
                end
                S_DISCARD: begin
                    if (imem_valid_i) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: head fields are masked while the queue is empty
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_data_i;
            r_pc_mem[r_wr_ptr]    <= r_req_pc;
        end
    end

    assign imem_req_o    = w_issue;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign pc_o          = w_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign pc_plus4_o    = w_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : '0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory model with programmable latency, a scoreboard
// filled at request time and drained on pops, plus a second instance exercising PC wrap.
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, redirect_i, imem_valid_i, instr_ready_i;
    logic [31:0] redirect_pc_i, imem_data_i;
    logic        imem_req_o, instr_valid_o;
    logic [31:0] imem_addr_o, instr_o, pc_o, pc_plus4_o;

    logic        req2, valid2, ivalid2, ready2, redirect2;
    logic [31:0] addr2, data2, instr2, pc2, plus4_2, redirect_pc2;

    int checks = 0;
    int errors = 0;
    int npops  = 0;
    int lat;
    int pend_cnt;
    logic        pend, pend2;
    logic [31:0] pend_addr, paddr2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] log2[$];

    instr_fetch_queue u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .instr_ready_i(instr_ready_i)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_valid_i(valid2), .imem_data_i(data2),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .instr_valid_o(ivalid2), .instr_o(instr2), .pc_o(pc2),
        .pc_plus4_o(plus4_2), .instr_ready_i(ready2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory model: response L cycles after the request; scoreboard entry created at request time
    always @(negedge clk) begin
        imem_valid_i = 1'b0;
        if (!rst_i) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_valid_i = 1'b1;
                    imem_data_i  = mem_word(pend_addr);
                    pend         = 1'b0;
                end
            end
            if (imem_req_o) begin
                chk("single_outstanding", 32'(pend), 32'd0);
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_addr = imem_addr_o;
                sb.push_back('{pc: imem_addr_o, word: mem_word(imem_addr_o)});
            end
        end
    end

    always @(negedge clk) begin
        valid2 = 1'b0;
        if (!rst_i) begin
            pend2 = 1'b0;
        end else begin
            if (pend2) begin
                valid2 = 1'b1;
                data2  = mem_word(paddr2);
                pend2  = 1'b0;
            end
            if (req2) begin
                pend2  = 1'b1;
                paddr2 = addr2;
                log2.push_back(addr2);
            end
        end
    end

    // Pop monitor: every accepted head must match the oldest surviving request
    always @(negedge clk) begin
        exp_t e;
        if (rst_i && !redirect_i && instr_valid_o && instr_ready_i) begin
            chk("pop_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", pc_o, e.pc);
                chk("pop_instr", instr_o, e.word);
                chk("pop_pc_plus4", pc_plus4_o, e.pc + 32'd4);
                npops++;
            end
        end
    end

    initial begin
        rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b1;
        imem_valid_i = 1'b0; imem_data_i = '0; lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
        ready2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; valid2 = 1'b0; data2 = '0;
        pend2 = 1'b0; paddr2 = '0;

        // Reset state
        cyc(3); #5;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc4", pc_plus4_o, 32'd0);
        chk("rst_wrap_req", 32'(req2), 32'd0);

        // Free run, L=1, ready=1
        cyc(1); rst_i = 1'b1; #5;
        chk("run_req0", 32'(imem_req_o), 32'd1);
        chk("run_addr0", imem_addr_o, 32'h0);
        chk("run_valid_r0", 32'(instr_valid_o), 32'd0);
        cyc(1); #5;
        chk("run_req_gap", 32'(imem_req_o), 32'd0);
        chk("run_valid_r1", 32'(instr_valid_o), 32'd0);
        cyc(1); #5;
        chk("run_valid_r2", 32'(instr_valid_o), 32'd1);
        chk("run_head_pc", pc_o, 32'h0);
        chk("run_head_pc4", pc_plus4_o, 32'h4);
        chk("run_req1", 32'(imem_req_o), 32'd1);
        chk("run_addr1", imem_addr_o, 32'h4);
        cyc(2); #5;
        chk("run_addr2", imem_addr_o, 32'h8);

        // Wrap instance: four entries from 0xFFFF_FFF8 upward, then one pop
        cyc(4); #5;
        chk("wrap_full_valid", 32'(ivalid2), 32'd1);
        chk("wrap_full_req", 32'(req2), 32'd0);
        chk("wrap_head_pc", pc2, 32'hFFFF_FFF8);
        chk("wrap_head_pc4", plus4_2, 32'hFFFF_FFFC);
        cyc(1); ready2 = 1'b1; #5;
        cyc(1); ready2 = 1'b0; #5;
        chk("wrap_pc2", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc2_plus4", plus4_2, 32'h0);
        chk("wrap_instr2", instr2, mem_word(32'hFFFF_FFFC));
        chk("wrap_log_n", 32'(log2.size() >= 3), 32'd1);
        chk("wrap_addr0", log2[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", log2[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", log2[2], 32'h0);

        // Fill with ready=0
        cyc(1); rst_i = 1'b0; instr_ready_i = 1'b0; sb.delete(); #5;
        cyc(1); #5;
        cyc(1); rst_i = 1'b1; #5;
        chk("fill_req0", imem_addr_o, 32'h0);
        cyc(8); #5;
        chk("fill_req_stop", 32'(imem_req_o), 32'd0);
        chk("fill_valid", 32'(instr_valid_o), 32'd1);
        chk("fill_head", pc_o, 32'h0);
        cyc(2); #5;
        chk("fill_req_still0", 32'(imem_req_o), 32'd0);
        chk("fill_head_stable", pc_o, 32'h0);
        chk("fill_instr_stable", instr_o, mem_word(32'h0));
        cyc(1); instr_ready_i = 1'b1; #5;
        chk("fill_pop_head", pc_o, 32'h0);
        cyc(1); #5;
        chk("fill_req_resume", 32'(imem_req_o), 32'd1);
        chk("fill_addr_resume", imem_addr_o, 32'h10);
        chk("fill_next_head", pc_o, 32'h4);

        // Redirect while waiting, L=3
        cyc(1); rst_i = 1'b0; lat = 3; sb.delete(); #5;
        cyc(1); #5;
        cyc(1); rst_i = 1'b1; #5;
        chk("rd_req0", 32'(imem_req_o), 32'd1);
        cyc(1); redirect_i = 1'b1; redirect_pc_i = 32'h103; sb.delete(); #5;
        chk("rd_no_req_redirect", 32'(imem_req_o), 32'd0);
        cyc(1); redirect_i = 1'b0; #5;
        chk("rd_valid_after", 32'(instr_valid_o), 32'd0);
        chk("rd_discard_req", 32'(imem_req_o), 32'd0);
        cyc(1); #5;
        chk("rd_discard_req2", 32'(imem_req_o), 32'd0);
        cyc(1); #5;
        chk("rd_new_req", 32'(imem_req_o), 32'd1);
        chk("rd_new_addr", imem_addr_o, 32'h100);
        chk("rd_dropped", 32'(instr_valid_o), 32'd0);
        cyc(4); #5;
        chk("rd_first_valid", 32'(instr_valid_o), 32'd1);
        chk("rd_first_pc", pc_o, 32'h100);

        // Redirect coinciding with a response and a pop
        cyc(1); rst_i = 1'b0; lat = 1; instr_ready_i = 1'b0; sb.delete(); #5;
        cyc(1); #5;
        cyc(1); rst_i = 1'b1; #5;
        chk("co_req0", imem_addr_o, 32'h0);
        cyc(3); redirect_i = 1'b1; redirect_pc_i = 32'h1234_567B; instr_ready_i = 1'b1; sb.delete(); #5;
        chk("co_valid_before", 32'(instr_valid_o), 32'd1);
        chk("co_no_req", 32'(imem_req_o), 32'd0);
        cyc(1); redirect_i = 1'b0; #5;
        chk("co_flushed", 32'(instr_valid_o), 32'd0);
        chk("co_req", 32'(imem_req_o), 32'd1);
        chk("co_addr", imem_addr_o, 32'h1234_5678);
        cyc(2); #5;
        chk("co_head_pc", pc_o, 32'h1234_5678);
        chk("co_head_pc4", pc_plus4_o, 32'h1234_567C);

        // Reset in the middle of a fetch with two entries queued
        cyc(1); rst_i = 1'b0; instr_ready_i = 1'b0; sb.delete(); #5;
        cyc(1); #5;
        cyc(1); rst_i = 1'b1; #5;
        cyc(3); #5;
        cyc(1); lat = 3; #5;
        chk("mr_req", imem_addr_o, 32'h8);
        chk("mr_queued", 32'(instr_valid_o), 32'd1);
        cyc(1); rst_i = 1'b0; sb.delete(); #5;
        chk("mr_req_forced", 32'(imem_req_o), 32'd0);
        cyc(1); #5;
        chk("mr_valid", 32'(instr_valid_o), 32'd0);
        chk("mr_req_low", 32'(imem_req_o), 32'd0);
        chk("mr_pc_zero", pc_o, 32'h0);
        cyc(1); rst_i = 1'b1; instr_ready_i = 1'b1; #5;
        chk("mr_restart_req", 32'(imem_req_o), 32'd1);
        chk("mr_restart_addr", imem_addr_o, 32'h0);
        cyc(12); #5;
        chk("pops_seen", 32'(npops > 8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
